// File: rtl/predecode_ras_stage_pkg.sv
// Shared constants and types for the pre-decode / return-address-stack stage.
package predecode_ras_stage_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 64;
    localparam int unsigned OP_W   = 6;

    // Alpha major opcodes of interest
    localparam logic [OP_W-1:0] JSR_GRP = 6'h1a;
    localparam logic [OP_W-1:0] LDQ     = 6'h29;
    localparam logic [OP_W-1:0] LDQ_L   = 6'h2b;
    localparam logic [OP_W-1:0] BR      = 6'h30;
    localparam logic [OP_W-1:0] FBEQ    = 6'h31;
    localparam logic [OP_W-1:0] FBLT    = 6'h32;
    localparam logic [OP_W-1:0] FBLE    = 6'h33;
    localparam logic [OP_W-1:0] BSR     = 6'h34;
    localparam logic [OP_W-1:0] FBNE    = 6'h35;
    localparam logic [OP_W-1:0] FBGE    = 6'h36;
    localparam logic [OP_W-1:0] FBGT    = 6'h37;
    localparam logic [OP_W-1:0] BLBC    = 6'h38;

    // Hint field of the JSR group that marks a return
    localparam logic [1:0] RET_HINT = 2'b10;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Classification of a single instruction
    typedef struct packed {
        logic cond;
        logic uncond;
        logic bsr;
        logic ret;
        logic call;
        logic ldq;
    } slot_flags_t;

    // Floating-point conditional branch opcodes
    function automatic logic is_fp_branch(input logic [OP_W-1:0] op);
        return (op == FBEQ) || (op == FBLT) || (op == FBLE) ||
               (op == FBNE) || (op == FBGE) || (op == FBGT);
    endfunction

endpackage

// File: rtl/predecode_slot.sv
// Combinational classifier for one Alpha instruction.
// PREDECODE_FP_BRANCH_EN: when defined, FP branches are flagged as conditional.
module predecode_slot
    import predecode_ras_stage_pkg::*;
(
    input  logic [INST_W-1:0] i_inst,
    output slot_flags_t       o_flags_c
);

    logic [OP_W-1:0] w_op;
    logic [1:0]      w_hint;
    logic            w_unused;

    assign w_op     = i_inst[31:26];
    assign w_hint   = i_inst[15:14];
    assign w_unused = ^{i_inst[25:16], i_inst[13:0]};

    // Opcode decode into branch / call / return / load flags
    always_comb begin
        o_flags_c = '0;
        if (w_op == JSR_GRP) begin
            o_flags_c.uncond = TRUE;
            o_flags_c.ret    = (w_hint == RET_HINT);
            o_flags_c.call   = w_hint[0];
        end
        if (w_op == BR) begin
            o_flags_c.uncond = TRUE;
        end
        if (w_op == BSR) begin
            o_flags_c.uncond = TRUE;
            o_flags_c.bsr    = TRUE;
            o_flags_c.call   = TRUE;
        end
        if (w_op >= BLBC) begin
            o_flags_c.cond = TRUE;
        end
`ifdef PREDECODE_FP_BRANCH_EN
        if (is_fp_branch(w_op)) begin
            o_flags_c.cond = TRUE;
        end
`else
        // FP branches remain plain valid slots
`endif
        if ((w_op == LDQ) || (w_op == LDQ_L)) begin
            o_flags_c.ldq = TRUE;
        end
    end

endmodule

// File: rtl/predecode_ras_stage.sv
// Registered N-wide pre-decode stage with a circular return-address stack.
// PREDECODE_FP_BRANCH_EN (in predecode_slot) enables FP-branch cond flags.
module predecode_ras_stage
    import predecode_ras_stage_pkg::*;
#(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [INST_W*WIDTH-1:0]      in_inst,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_pc,
    output logic [WIDTH-1:0]             out_slot_valid,
    output logic [WIDTH-1:0]             out_cond,
    output logic [WIDTH-1:0]             out_uncond,
    output logic [WIDTH-1:0]             out_bsr,
    output logic [WIDTH-1:0]             out_ret,
    output logic [WIDTH-1:0]             out_ldq,
    output logic [XLEN-1:0]              out_ret_target,
    output logic                         out_ret_target_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    slot_flags_t          w_flags [WIDTH];
    logic [WIDTH-1:0]     w_slot_valid, w_cond, w_uncond, w_bsr, w_ret, w_ldq;
    logic                 w_has_call, w_has_ret, w_blocked;
    logic [XLEN-1:0]      w_link, w_slot_pc;
    logic                 w_capture, w_push, w_pop, w_ras_empty;
    logic [PTR_W-1:0]     w_top_m1;

    logic [XLEN-1:0]      r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]     r_top;
    logic [CNT_W-1:0]     r_count;

    logic                 r_out_valid;
    logic [XLEN-1:0]      r_out_pc;
    logic [WIDTH-1:0]     r_slot_valid, r_cond, r_uncond, r_bsr, r_ret, r_ldq;
    logic [XLEN-1:0]      r_ret_target;
    logic                 r_ret_target_valid;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slot
        predecode_slot u_slot (
            .i_inst    (in_inst[INST_W*g +: INST_W]),
            .o_flags_c (w_flags[g])
        );
    end

    // Squash slots after the first unconditional transfer; locate call / return
    always_comb begin
        w_slot_valid = '0;
        w_cond       = '0;
        w_uncond     = '0;
        w_bsr        = '0;
        w_ret        = '0;
        w_ldq        = '0;
        w_has_call   = FALSE;
        w_has_ret    = FALSE;
        w_link       = '0;
        w_blocked    = FALSE;
        w_slot_pc    = in_pc;
        for (int i = 0; i < WIDTH; i++) begin
            if (!w_blocked) begin
                w_slot_valid[i] = TRUE;
                w_cond[i]       = w_flags[i].cond;
                w_uncond[i]     = w_flags[i].uncond;
                w_bsr[i]        = w_flags[i].bsr;
                w_ret[i]        = w_flags[i].ret;
                w_ldq[i]        = w_flags[i].ldq;
                if (w_flags[i].call) begin
                    w_has_call = TRUE;
                    w_link     = w_slot_pc + 64'd4;
                end
                if (w_flags[i].ret) begin
                    w_has_ret = TRUE;
                end
                w_blocked = w_flags[i].uncond;
            end
            w_slot_pc = w_slot_pc + 64'd4;
        end
    end

    assign in_ready    = ~r_out_valid | out_ready;
    assign w_capture   = in_valid & in_ready & ~flush;
    assign w_push      = w_capture & w_has_call;
    assign w_pop       = w_capture & w_has_ret;
    assign w_ras_empty = (r_count == '0);
    assign w_top_m1    = r_top - PTR_W'(1);

    // Return-address stack: push overwrites oldest when full, pop on empty is a no-op
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_ras[r_top] <= w_link;
            r_top        <= r_top + PTR_W'(1);
            if (r_count != CNT_W'(RAS_DEPTH)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop && !w_ras_empty) begin
            r_top   <= w_top_m1;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Output register: flush beats capture, capture beats drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid        <= FALSE;
            r_out_pc           <= '0;
            r_slot_valid       <= '0;
            r_cond             <= '0;
            r_uncond           <= '0;
            r_bsr              <= '0;
            r_ret              <= '0;
            r_ldq              <= '0;
            r_ret_target       <= '0;
            r_ret_target_valid <= FALSE;
        end else if (flush) begin
            r_out_valid <= FALSE;
        end else if (w_capture) begin
            r_out_valid        <= TRUE;
            r_out_pc           <= in_pc;
            r_slot_valid       <= w_slot_valid;
            r_cond             <= w_cond;
            r_uncond           <= w_uncond;
            r_bsr              <= w_bsr;
            r_ret              <= w_ret;
            r_ldq              <= w_ldq;
            r_ret_target       <= (w_has_ret && !w_ras_empty) ? r_ras[w_top_m1] : '0;
            r_ret_target_valid <= w_has_ret & ~w_ras_empty;
        end else if (out_ready) begin
            r_out_valid <= FALSE;
        end
    end

    assign out_valid            = r_out_valid;
    assign out_pc               = r_out_pc;
    assign out_slot_valid       = r_slot_valid;
    assign out_cond             = r_cond;
    assign out_uncond           = r_uncond;
    assign out_bsr              = r_bsr;
    assign out_ret              = r_ret;
    assign out_ldq              = r_ldq;
    assign out_ret_target       = r_ret_target;
    assign out_ret_target_valid = r_ret_target_valid;
    assign ras_count            = r_count;

endmodule

// File: tb/tb_predecode_ras_stage.sv
// Scoreboard bench for predecode_ras_stage with a queue-based reference model.
module tb_predecode_ras_stage;

    localparam int unsigned W = 2;
    localparam int unsigned D = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_pc;
    logic [63:0]   in_inst;
    logic          flush;
    logic          out_ready;
    logic          out_valid;
    logic [63:0]   out_pc;
    logic [W-1:0]  out_slot_valid, out_cond, out_uncond, out_bsr, out_ret, out_ldq;
    logic [63:0]   out_ret_target;
    logic          out_ret_target_valid;
    logic [3:0]    ras_count;

    predecode_ras_stage #(.WIDTH(W), .RAS_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_slot_valid(out_slot_valid),
        .out_cond(out_cond), .out_uncond(out_uncond), .out_bsr(out_bsr),
        .out_ret(out_ret), .out_ldq(out_ldq), .out_ret_target(out_ret_target),
        .out_ret_target_valid(out_ret_target_valid), .ras_count(ras_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]  pc;
        logic [W-1:0] sv, cond, unc, bsr, ret, ldq;
        logic [63:0]  tgt;
        logic         tv;
        int unsigned  cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        p_exp;
    bit          p_push, p_drop;
    bit          m_valid;
    logic [63:0] m_ras[$];
    bit          mon_en;
    int          n_checks, n_pass;

    localparam logic [31:0] NOP   = 32'h47FF_041F;
    localparam logic [31:0] ADDQ  = 32'h4000_0400;
    localparam logic [31:0] I_BR  = 32'hC3E0_0000;
    localparam logic [31:0] I_BSR = 32'hD340_0000;
    localparam logic [31:0] I_RET = 32'h6BFA_8000;
    localparam logic [31:0] I_LDQ = 32'hA400_0000;
    localparam logic [31:0] I_LDL = 32'hAC00_0000;
    localparam logic [31:0] I_FB  = 32'hC400_0000;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-instruction classification straight from the opcode table
    function automatic void classify(input logic [31:0] ins, output bit cond, output bit unc,
                                     output bit bsr, output bit ret, output bit call, output bit ldq);
        int op, hfld;
        op   = int'(ins[31:26]);
        hfld = int'(ins[15:14]);
        cond = (op >= 'h38);
`ifdef PREDECODE_FP_BRANCH_EN
        if ((op >= 'h31 && op <= 'h33) || (op >= 'h35 && op <= 'h37)) cond = 1;
`endif
        unc  = (op == 'h1a) || (op == 'h30) || (op == 'h34);
        bsr  = (op == 'h34);
        ret  = (op == 'h1a) && (hfld == 2);
        call = ((op == 'h1a) && (hfld == 1 || hfld == 3)) || (op == 'h34);
        ldq  = (op == 'h29) || (op == 'h2b);
    endfunction

    // Expected group output; applies the group's call/return to the model stack
    function automatic exp_t model_group(input logic [63:0] pc, input logic [63:0] inst);
        exp_t e;
        bit alive, c, u, b, r, k, l;
        logic [31:0] ins;
        e = '{pc: pc, sv: '0, cond: '0, unc: '0, bsr: '0, ret: '0, ldq: '0, tgt: '0, tv: 0, cnt: 0};
        alive = 1;
        for (int i = 0; i < W; i++) begin
            ins = inst[32*i +: 32];
            classify(ins, c, u, b, r, k, l);
            if (alive) begin
                e.sv[i] = 1; e.cond[i] = c; e.unc[i] = u; e.bsr[i] = b; e.ret[i] = r; e.ldq[i] = l;
                if (k) begin
                    m_ras.push_back(pc + 64'(4 * i + 4));
                    if (m_ras.size() > D) void'(m_ras.pop_front());
                end
                if (r && m_ras.size() > 0) begin
                    e.tgt = m_ras.pop_back();
                    e.tv  = 1;
                end
                if (u) alive = 0;
            end
        end
        e.cnt = m_ras.size();
        return e;
    endfunction

    task automatic apply_pending();
        if (p_drop) void'(sb_q.pop_front());
        if (p_push) sb_q.push_back(p_exp);
        p_drop = 0;
        p_push = 0;
    endtask

    // One cycle: apply last edge's effects, drive new inputs, predict this edge
    task automatic step(input bit v, input logic [63:0] pc, input logic [63:0] inst,
                        input bit fl, input bit ordy);
        bit cap, rdy;
        @(posedge clock);
        #1;
        apply_pending();
        chk("ras_count_track", ras_count === 4'(m_ras.size()), 64'(ras_count), 64'(m_ras.size()));
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        flush     = fl;
        out_ready = ordy;
        rdy = !m_valid || ordy;
        cap = v && rdy && !fl;
        if (cap) begin
            p_exp  = model_group(pc, inst);
            p_push = 1;
        end
        p_drop  = fl && m_valid && !ordy;
        m_valid = fl ? 0 : (cap ? 1 : (ordy ? 0 : m_valid));
        #1;
        chk("in_ready", in_ready === rdy, 64'(in_ready), 64'(rdy));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [5:0]  op;
        int k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0:       begin op = 6'h1a; r[15:14] = 2'b10; end
            1:       op = 6'h1a;
            2, 3:    op = 6'h34;
            4:       op = 6'h30;
            5:       op = 6'(6'h38 + 6'($urandom_range(0, 7)));
            6:       op = 6'($urandom_range(0, 1) != 0 ? 6'h31 : 6'h35 + 6'($urandom_range(0, 2)));
            7:       op = 6'h29;
            8:       op = 6'h2b;
            default: op = 6'(r[31:26]);
        endcase
        return {op, r[25:0]};
    endfunction

    // Monitor: every presented group must match the head of the scoreboard
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            chk("out_valid", out_valid === (sb_q.size() != 0), 64'(out_valid), 64'(sb_q.size()));
            if (out_valid && sb_q.size() != 0) begin
                chk("out_pc", out_pc === sb_q[0].pc, out_pc, sb_q[0].pc);
                chk("slot_valid", out_slot_valid === sb_q[0].sv, 64'(out_slot_valid), 64'(sb_q[0].sv));
                chk("flags {cond,unc,bsr,ret,ldq}",
                    {out_cond, out_uncond, out_bsr, out_ret, out_ldq} ===
                    {sb_q[0].cond, sb_q[0].unc, sb_q[0].bsr, sb_q[0].ret, sb_q[0].ldq},
                    64'({out_cond, out_uncond, out_bsr, out_ret, out_ldq}),
                    64'({sb_q[0].cond, sb_q[0].unc, sb_q[0].bsr, sb_q[0].ret, sb_q[0].ldq}));
                chk("ret_target", out_ret_target === sb_q[0].tgt, out_ret_target, sb_q[0].tgt);
                chk("ret_target_valid", out_ret_target_valid === sb_q[0].tv,
                    64'(out_ret_target_valid), 64'(sb_q[0].tv));
                chk("ras_count_out", ras_count === 4'(sb_q[0].cnt), 64'(ras_count), 64'(sb_q[0].cnt));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] pc;
        n_checks = 0; n_pass = 0;
        p_push = 0; p_drop = 0; m_valid = 0; mon_en = 0;
        reset = 1; in_valid = 0; in_pc = '0; in_inst = '0; flush = 0; out_ready = 0;
        #1;
        chk("reset out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
        chk("reset ras_count", ras_count === 4'd0, 64'(ras_count), 64'd0);
        chk("reset out_pc", out_pc === 64'd0, out_pc, 64'd0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 0;
        mon_en = 1;

        // BR in slot 0 squashes slot 1
        step(1, 64'h1000, {ADDQ, I_BR}, 0, 1);
        step(0, 64'h0, 64'h0, 0, 1);
        // BSR at slot 1, then RET
        step(1, 64'h2000, {I_BSR, NOP}, 0, 1);
        step(1, 64'h3000, {NOP, I_RET}, 0, 1);
        step(0, 64'h0, 64'h0, 0, 1);
        // Overflow the stack, then unwind past empty
        for (int i = 0; i < 9; i++) step(1, 64'h4000 + 64'(i * 64), {NOP, I_BSR}, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 64'h8000 + 64'(i * 64), {NOP, I_RET}, 0, 1);
        // Hold for 3 cycles, then flush a BSR
        step(1, 64'h5000, {NOP, I_LDQ}, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 64'h6000, {NOP, I_BSR}, 0, 0);
        step(1, 64'h6000, {NOP, I_BSR}, 1, 0);
        step(0, 64'h0, 64'h0, 0, 1);
        // Loads and FP branch
        step(1, 64'h7000, {I_LDL, I_LDQ}, 0, 1);
        step(1, 64'h7100, {NOP, I_FB}, 0, 1);
        // Wrap-around link address
        step(1, 64'hFFFF_FFFF_FFFF_FFF8, {I_BSR, NOP}, 0, 1);
        step(1, 64'h7200, {NOP, I_RET}, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            pc = {32'($urandom), 32'($urandom)} & ~64'h3;
            if ($urandom_range(0, 15) == 0) pc = 64'hFFFF_FFFF_FFFF_FFFC;
            step($urandom_range(0, 3) != 0, pc, {rand_inst(), rand_inst()},
                 $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end

        // Reach out_valid=1 with three stacked calls, then reset asynchronously
        for (int i = 0; i < 9; i++) step(1, 64'h9000, {NOP, I_RET}, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 64'hA000 + 64'(i * 16), {NOP, I_BSR}, 0, 1);
        step(0, 64'h0, 64'h0, 0, 0);
        @(posedge clock);
        #1;
        apply_pending();
        chk("pre-reset out_valid", out_valid === 1'b1, 64'(out_valid), 64'd1);
        chk("pre-reset ras_count", ras_count === 4'd3, 64'(ras_count), 64'd3);
        #1;
        reset = 1;
        #1;
        chk("async reset out_valid", out_valid === 1'b0, 64'(out_valid), 64'd0);
        chk("async reset ras_count", ras_count === 4'd0, 64'(ras_count), 64'd0);
        chk("async reset out_pc", out_pc === 64'd0, out_pc, 64'd0);
        chk("async reset slot flags",
            {out_slot_valid, out_cond, out_uncond, out_bsr, out_ret, out_ldq} === '0,
            64'({out_slot_valid, out_cond, out_uncond, out_bsr, out_ret, out_ldq}), 64'd0);
        chk("async reset ret_target", {out_ret_target_valid, out_ret_target} === 65'd0,
            out_ret_target, 64'd0);
        sb_q.delete();
        m_ras.delete();
        m_valid = 0;
        p_push = 0;
        p_drop = 0;
        #1;
        reset = 0;
        // After reset the stack is empty: a RET predicts nothing
        step(1, 64'hB000, {NOP, I_RET}, 0, 1);
        step(0, 64'h0, 64'h0, 0, 1);
        step(0, 64'h0, 64'h0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
